// File: rtl/sec_imul_ctrl.sv
// Iterative shift-add multiplier controller producing the low p_nbits of in_a*in_b.
// Constant latency by default; define SEC_IMUL_EARLY_EXIT_EN for data-dependent early exit.
module sec_imul_ctrl #(
  parameter int unsigned p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sd,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in_a,
  input  logic [p_nbits-1:0] in_b,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_result
);

  localparam int unsigned CNT_W = $clog2(p_nbits) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(p_nbits - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [p_nbits-1:0] a_q, a_d;
  logic [p_nbits-1:0] b_q, b_d;
  logic [p_nbits-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_rdy_q, in_rdy_d;
  logic               out_val_q, out_val_d;

  // sd is a public label carried alongside the operands; the datapath never inspects it.
  logic unused_sd;
  assign unused_sd = sd;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_val && in_rdy_q) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = DONE;
`ifdef SEC_IMUL_EARLY_EXIT_EN
        // Remaining multiplier bits are all zero, so further iterations cannot change acc.
        if (b_d == '0) state_d = DONE;
`endif
      end
      DONE: begin
        if (out_val_q && out_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered copies of the next state, so no input reaches them combinationally.
    in_rdy_d  = (state_d == IDLE);
    out_val_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      in_rdy_q  <= 1'b1;
      out_val_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      in_rdy_q  <= in_rdy_d;
      out_val_q <= out_val_d;
    end
  end

  assign in_rdy     = in_rdy_q;
  assign out_val    = out_val_q;
  assign out_result = acc_q;

endmodule

// File: tb/tb_sec_imul_ctrl.sv
// Self-checking bench for sec_imul_ctrl: directed table, corner sequences and random ops
// compared against an arithmetic reference model of product and latency.
module tb_sec_imul_ctrl;

  localparam int unsigned P = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         sd;
  logic         in_val;
  logic         in_rdy;
  logic [P-1:0] in_a;
  logic [P-1:0] in_b;
  logic         out_val;
  logic         out_rdy;
  logic [P-1:0] out_result;

  int n_vec  = 0;
  int n_miss = 0;

  sec_imul_ctrl #(.p_nbits(P)) dut (
    .clk        (clk),
    .reset      (reset),
    .sd         (sd),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .out_result (out_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [P-1:0] a;
    logic [P-1:0] b;
    logic [P-1:0] exp;
    int           stall;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference product: full-width multiply, keep the low P bits.
  function automatic logic [P-1:0] ref_mul(input logic [P-1:0] a, input logic [P-1:0] b);
    logic [2*P-1:0] full;
    full = {{P{1'b0}}, a} * {{P{1'b0}}, b};
    return full[P-1:0];
  endfunction

  // Reference latency: cycle number (acceptance edge starts cycle 1) in which out_val is first seen.
  function automatic int ref_lat(input logic [P-1:0] b);
    int calc;
`ifdef SEC_IMUL_EARLY_EXIT_EN
    calc = 1;
    for (int i = 0; i < P; i++) if (b[i]) calc = i + 1;
`else
    calc = P;
`endif
    return calc + 1;
  endfunction

  task automatic do_op(input string name, input logic [P-1:0] a, input logic [P-1:0] b,
                       input logic [P-1:0] exp, input int stall);
    int waited;
    int lat;
    waited = 0;
    while (!in_rdy && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check({name, "_rdy_timeout"}, 0, 1);
    out_rdy = (stall == 0);
    in_a    = a;
    in_b    = b;
    in_val  = 1'b1;
    @(negedge clk);
    in_val = 1'b0;
    in_a   = $urandom;
    in_b   = $urandom;
    lat = 1;
    while (!out_val && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"}, 64'(lat), 64'(ref_lat(b)));
    check({name, "_res"}, 64'(out_result), 64'(exp));
    if (stall > 0) begin
      in_val = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check({name, "_stall_val"}, 64'(out_val), 64'd1);
        check({name, "_stall_res"}, 64'(out_result), 64'(exp));
        check({name, "_stall_rdy"}, 64'(in_rdy), 64'd0);
      end
      in_val  = 1'b0;
      out_rdy = 1'b1;
    end
    @(negedge clk);
    check({name, "_pulse_end"}, 64'(out_val), 64'd0);
    check({name, "_rdy_after"}, 64'(in_rdy), 64'd1);
    if (stall > 0) begin
      @(negedge clk);
      check({name, "_no_accept"}, 64'(in_rdy), 64'd1);
    end
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{a: 32'd3,          b: 32'd5,          exp: 32'd15,       stall: 0};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  exp: 32'h0000_0001, stall: 0};
    vecs[2] = '{a: 32'h8000_0000,  b: 32'd2,          exp: 32'h0000_0000, stall: 0};
    vecs[3] = '{a: 32'h0000_1234,  b: 32'h10,         exp: 32'h0001_2340, stall: 10};
    vecs[4] = '{a: 32'hDEAD_BEEF,  b: 32'd0,          exp: 32'd0,         stall: 0};
    vecs[5] = '{a: 32'd1,          b: 32'h8000_0000,  exp: 32'h8000_0000, stall: 0};
    vecs[6] = '{a: 32'd21,         b: 32'd2,          exp: 32'd42,        stall: 1};

    sd = 1'b0; in_a = '0; in_b = '0; out_rdy = 1'b1;
    reset = 1'b0; in_val = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_in_rdy", 64'(in_rdy), 64'd1);
    check("reset_out_val", 64'(out_val), 64'd0);
    check("reset_out_result", 64'(out_result), 64'd0);
    in_val = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 64'(in_rdy), 64'd1);

    for (int i = 0; i < 7; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stall);

    // Abort mid-calculation: reset in CALC cycle 10 must drop the operation silently.
    out_rdy = 1'b1;
    in_a = 32'd100; in_b = 32'd100; in_val = 1'b1;
    @(negedge clk);
    in_val = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_in_rdy", 64'(in_rdy), 64'd1);
    check("abort_out_val", 64'(out_val), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (out_val) seen++;
      end
      check("abort_no_response", 64'(seen), 64'd0);
    end
    do_op("after_abort", 32'd7, 32'd6, 32'd42, 0);

    for (int i = 0; i < 20; i++) begin
      logic [P-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 1) rb = rb >> $urandom_range(P - 1, 20);
      sd = 1'($urandom_range(1, 0));
      do_op($sformatf("rand%0d", i), ra, rb, ref_mul(ra, rb), int'($urandom_range(3, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
